// File: rtl/packed_cmd_executor.sv
// packed_cmd_executor: takes packed {write_not_read, addr[22:0], data[7:0]}
// commands through a 2-entry FIFO, replays them as byte accesses on a
// valid/ready memory port and returns read bytes on a response channel.
// Wrapping counters of completed writes and reads are kept for debug.
module packed_cmd_executor #(
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [31:0]              cmd_data_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  output logic [31:0]              resp_data_o,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [22:0]              mem_addr_o,
  output logic [7:0]               mem_data_o,
  output logic                     mem_w_o,
  output logic                     mem_v_o,
  input  logic                     mem_ready_i,
  input  logic [7:0]               mem_data_i,
  input  logic                     mem_v_i,
  output logic [count_width_p-1:0] wr_count_o,
  output logic [count_width_p-1:0] rd_count_o
);

  typedef enum logic [1:0] {
    e_ready,
    e_read_wait,
    e_resp
  } state_e;

  state_e state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [31:0] fifo_mem_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  fifo_cnt_reg;
  logic        fifo_full;
  logic        fifo_v;
  logic        fifo_enq;
  logic        fifo_deq;
  logic [31:0] fifo_head;

  logic        resp_capture;
  logic        wr_inc;
  logic        rd_inc;
  logic [31:0] resp_data_reg;
  logic [count_width_p-1:0] wr_count_reg;
  logic [count_width_p-1:0] rd_count_reg;

  assign fifo_full   = (fifo_cnt_reg == 2'd2);
  assign fifo_v      = (fifo_cnt_reg != 2'd0);
  assign fifo_head   = fifo_mem_reg[rd_ptr_reg];
  // Ready is held low for as long as reset is asserted, independent of the clock.
  assign cmd_ready_o = ~fifo_full & ~reset_i;
  assign fifo_enq    = cmd_v_i & cmd_ready_o;

  // Request fields always come from the FIFO head (zero after reset), never X.
  assign mem_w_o    = fifo_head[31];
  assign mem_addr_o = fifo_head[30:8];
  assign mem_data_o = fifo_head[7:0];

  assign resp_data_o = resp_data_reg;
  assign wr_count_o  = wr_count_reg;
  assign rd_count_o  = rd_count_reg;

  // One storage slot per entry; a slot is written when the write pointer selects it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // Capture an accepted command into this slot.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          fifo_mem_reg[gi] <= 32'd0;
        end else if (fifo_enq && (wr_ptr_reg == 1'(gi))) begin
          fifo_mem_reg[gi] <= cmd_data_i;
        end
      end
    end
  endgenerate

  // Advance FIFO pointers and occupancy on enqueue/dequeue.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
    end else begin
      if (fifo_enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (fifo_deq) rd_ptr_reg <= ~rd_ptr_reg;
      case ({fifo_enq, fifo_deq})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= e_ready;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake decode; a read blocks everything behind it
  // until its response has been taken.
  always_comb begin
    state_next   = state_reg;
    mem_v_o      = 1'b0;
    resp_v_o     = 1'b0;
    fifo_deq     = 1'b0;
    resp_capture = 1'b0;
    wr_inc       = 1'b0;
    rd_inc       = 1'b0;
    case (state_reg)
      e_ready: begin
        mem_v_o = fifo_v;
        if (fifo_v && mem_ready_i) begin
          fifo_deq = 1'b1;
          if (fifo_head[31]) begin
            wr_inc = 1'b1;
          end else begin
            state_next = e_read_wait;
          end
        end
      end
      e_read_wait: begin
        if (mem_v_i) begin
          resp_capture = 1'b1;
          state_next   = e_resp;
        end
      end
      e_resp: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) begin
          rd_inc     = 1'b1;
          state_next = e_ready;
        end
      end
      default: state_next = e_ready;
    endcase
  end

  // Response register: loaded once per read, held until the next read returns.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_data_reg <= 32'd0;
    end else if (resp_capture) begin
      resp_data_reg <= {24'd0, mem_data_i};
    end
  end

  // Completion counters, free-running modulo 2^count_width_p.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_count_reg <= '0;
      rd_count_reg <= '0;
    end else begin
      if (wr_inc) wr_count_reg <= wr_count_reg + 1'b1;
      if (rd_inc) rd_count_reg <= rd_count_reg + 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Read data arriving with no read outstanding is dropped; report it.
  spurious_mem_v_a: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_v_i |-> (state_reg == e_read_wait))
    else $warning("packed_cmd_executor: mem_v_i with no read outstanding was ignored");
`endif

endmodule
